// File: rtl/uart_tx_sched.sv
// uart_tx_sched: drains the TX sync FIFO into the uart_tx shifter one byte at
// a time. It handles the FIFO's 1-cycle read latency, presents each byte on a
// valid/ready handshake, inserts a programmable inter-frame gap and supports a
// FIFO flush.
// Optional build macro UART_TX_CTS_EN adds an active-low clear-to-send input
// (cts_n) that gates the start of each new byte.
module uart_tx_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_W      = 8,
    parameter int CNT_W      = 16
) (
`ifdef UART_TX_CTS_EN
    input  logic                  cts_n,
`endif
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  flush,
    input  logic [GAP_W-1:0]      gap_cycles,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ready,
    output logic                  tx_done,
    output logic                  busy,
    output logic [CNT_W-1:0]      sent_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        LOAD  = 3'd2,
        SEND  = 3'd3,
        GAP   = 3'd4,
        FLUSH = 3'd5
    } state_t;

    state_t             state, state_n;
    logic [GAP_W-1:0]   gap_cnt;
    logic               flush_pend;
    logic               cts_ok;

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync;

    // Two-flop synchroniser; resets to "not clear" so nothing starts until
    // the synchronised line has actually been seen low.
    always_ff @(posedge clk) begin
        if (rst) cts_sync <= 2'b11;
        else     cts_sync <= {cts_sync[0], cts_n};
    end

    assign cts_ok = ~cts_sync[1];
`else
    assign cts_ok = 1'b1;
`endif

    // State register, output byte, sent counter, gap counter and flush request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx_data    <= '0;
            sent_cnt   <= '0;
            gap_cnt    <= '0;
            flush_pend <= 1'b0;
        end else begin
            state <= state_n;
            if (state == LOAD)
                tx_data <= fifo_rd_data;
            if (state == SEND && tx_ready)
                sent_cnt <= sent_cnt + 1'b1;
            // Load gap-1 on entry so GAP spans exactly gap_cycles cycles.
            if (state == SEND && tx_ready && gap_cycles != '0)
                gap_cnt <= gap_cycles - 1'b1;
            else if (state == GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
            // A new flush pulse wins over the clear on FLUSH entry.
            if (flush)
                flush_pend <= 1'b1;
            else if (state == IDLE && flush_pend)
                flush_pend <= 1'b0;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_n  = state;
        fifo_rd  = 1'b0;
        tx_valid = 1'b0;
        tx_done  = 1'b0;
        case (state)
            IDLE: begin
                if (flush_pend)
                    state_n = FLUSH;
                else if (tx_en && !fifo_empty && cts_ok)
                    state_n = RD;
            end
            RD: begin
                fifo_rd = 1'b1;
                state_n = LOAD;
            end
            LOAD: state_n = SEND;
            SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    tx_done = 1'b1;
                    state_n = (gap_cycles != '0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (flush_pend || gap_cnt == '0)
                    state_n = IDLE;
            end
            FLUSH: begin
                fifo_rd = ~fifo_empty;
                if (fifo_empty)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
